uart_engine: RTL and testbench



---
 rtl/uart_engine.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_uart_engine.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_engine.sv
// Full-duplex UART: TX/RX FIFOs, 16x oversample tick, runtime divider, parity, error capture.
// Define UART_LOOPBACK_EN to add the LOOPBACK input (RX FSM fed from internal TX, pin TX held 1).
module uart_engine #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DEFAULT_DIV = 26
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              TX_FULL,
  output logic              TX_BUSY,
  input  logic              RD_EN,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_PERR,
  output logic              RD_FERR,
  output logic              RX_EMPTY,
  output logic              RX_OVERRUN,
  input  logic              CFG_WE,
  input  logic [15:0]       CFG_DIV,
  input  logic [1:0]        CFG_PARITY,
  input  logic              CFG_STOP2,
  output logic              IRQ,
`ifdef UART_LOOPBACK_EN
  input  logic              LOOPBACK,
`endif
  input  logic              RX,
  output logic              TX
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = DATA_W + 2;

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxPar, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxPar, RxStop, RxWait} rx_state_e;

  logic [15:0] div_q;
  logic [1:0]  parity_q;
  logic        stop2_q;
  logic [15:0] tick_cnt_q;
  logic        tick;
  logic        lb;

`ifdef UART_LOOPBACK_EN
  assign lb = LOOPBACK;
`else
  assign lb = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_q    <= 16'(DEFAULT_DIV);
      parity_q <= 2'b00;
      stop2_q  <= 1'b0;
    end else if (CFG_WE) begin
      div_q    <= CFG_DIV;
      parity_q <= CFG_PARITY;
      stop2_q  <= CFG_STOP2;
    end
  end

  assign tick = (tick_cnt_q == 16'd0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_cnt_q <= 16'(DEFAULT_DIV);
    end else if (CFG_WE) begin
      tick_cnt_q <= CFG_DIV;
    end else if (tick) begin
      tick_cnt_q <= div_q;
    end else begin
      tick_cnt_q <= tick_cnt_q - 16'd1;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]       tx_wptr_q, tx_rptr_q;
  logic              tx_empty, tx_full, tx_push, tx_pop;
  logic [DATA_W-1:0] tx_head;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                    (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
  assign tx_push  = WR_EN && (!tx_full || tx_pop);
  assign tx_head  = tx_mem[tx_rptr_q[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= WR_DATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_e         tx_state_q;
  logic              tx_q;
  logic [4:0]        tx_tcnt_q;
  logic [3:0]        tx_bit_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic              tx_par_bit_q, tx_par_en_q, tx_stop2_q;
  logic [4:0]        tx_stop_last;

  assign tx_stop_last = tx_stop2_q ? 5'd31 : 5'd15;
  // End of STOP chains straight into the next frame so back-to-back frames have no gap.
  assign tx_pop = tick && !tx_empty &&
                  ((tx_state_q == TxIdle) ||
                   ((tx_state_q == TxStop) && (tx_tcnt_q == tx_stop_last)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state_q   <= TxIdle;
      tx_q         <= 1'b1;
      tx_tcnt_q    <= '0;
      tx_bit_q     <= '0;
      tx_sh_q      <= '0;
      tx_par_bit_q <= 1'b0;
      tx_par_en_q  <= 1'b0;
      tx_stop2_q   <= 1'b0;
    end else if (tx_pop) begin
      tx_state_q   <= TxStart;
      tx_q         <= 1'b0;
      tx_tcnt_q    <= '0;
      tx_sh_q      <= tx_head;
      tx_par_bit_q <= (parity_q == 2'b10) ? ~^tx_head : ^tx_head;
      tx_par_en_q  <= (parity_q == 2'b01) || (parity_q == 2'b10);
      tx_stop2_q   <= stop2_q;
    end else if (tick) begin
      case (tx_state_q)
        TxIdle: ;
        TxStart: begin
          if (tx_tcnt_q == 5'd15) begin
            tx_q       <= tx_sh_q[0];
            tx_sh_q    <= tx_sh_q >> 1;
            tx_bit_q   <= '0;
            tx_tcnt_q  <= '0;
            tx_state_q <= TxData;
          end else begin
            tx_tcnt_q <= tx_tcnt_q + 5'd1;
          end
        end
        TxData: begin
          if (tx_tcnt_q == 5'd15) begin
            tx_tcnt_q <= '0;
            if (tx_bit_q == 4'(DATA_W - 1)) begin
              tx_q       <= tx_par_en_q ? tx_par_bit_q : 1'b1;
              tx_state_q <= tx_par_en_q ? TxPar : TxStop;
            end else begin
              tx_q     <= tx_sh_q[0];
              tx_sh_q  <= tx_sh_q >> 1;
              tx_bit_q <= tx_bit_q + 4'd1;
            end
          end else begin
            tx_tcnt_q <= tx_tcnt_q + 5'd1;
          end
        end
        TxPar: begin
          if (tx_tcnt_q == 5'd15) begin
            tx_q       <= 1'b1;
            tx_tcnt_q  <= '0;
            tx_state_q <= TxStop;
          end else begin
            tx_tcnt_q <= tx_tcnt_q + 5'd1;
          end
        end
        TxStop: begin
          if (tx_tcnt_q == tx_stop_last) begin
            tx_state_q <= TxIdle;
          end else begin
            tx_tcnt_q <= tx_tcnt_q + 5'd1;
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  assign TX      = lb ? 1'b1 : tx_q;
  assign TX_BUSY = (tx_state_q != TxIdle) || !tx_empty;
  assign TX_FULL = tx_full;

  // ---------------- RX FSM ----------------
  logic              rx_meta_q, rx_sync_q, rx_in;
  rx_state_e         rx_state_q;
  logic [3:0]        rx_tcnt_q;
  logic [3:0]        rx_bit_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic              rx_par_en_q, rx_odd_q, rx_perr_q;
  logic              rx_push_q;
  logic [EW-1:0]     rx_push_data_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign rx_in = lb ? tx_q : rx_sync_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state_q     <= RxIdle;
      rx_tcnt_q      <= '0;
      rx_bit_q       <= '0;
      rx_sh_q        <= '0;
      rx_par_en_q    <= 1'b0;
      rx_odd_q       <= 1'b0;
      rx_perr_q      <= 1'b0;
      rx_push_q      <= 1'b0;
      rx_push_data_q <= '0;
    end else begin
      rx_push_q <= 1'b0;
      case (rx_state_q)
        RxIdle: begin
          if (!rx_in) begin
            rx_state_q  <= RxStart;
            rx_tcnt_q   <= '0;
            rx_perr_q   <= 1'b0;
            rx_par_en_q <= (parity_q == 2'b01) || (parity_q == 2'b10);
            rx_odd_q    <= (parity_q == 2'b10);
          end
        end
        RxStart: begin
          if (tick) begin
            // Mid-start sample; every later sample is 16 ticks after it.
            if (rx_tcnt_q == 4'd7) begin
              rx_tcnt_q  <= '0;
              rx_bit_q   <= '0;
              rx_state_q <= rx_in ? RxIdle : RxData;
            end else begin
              rx_tcnt_q <= rx_tcnt_q + 4'd1;
            end
          end
        end
        RxData: begin
          if (tick) begin
            rx_tcnt_q <= rx_tcnt_q + 4'd1;
            if (rx_tcnt_q == 4'd15) begin
              rx_sh_q <= {rx_in, rx_sh_q[DATA_W-1:1]};
              if (rx_bit_q == 4'(DATA_W - 1)) begin
                rx_state_q <= rx_par_en_q ? RxPar : RxStop;
              end else begin
                rx_bit_q <= rx_bit_q + 4'd1;
              end
            end
          end
        end
        RxPar: begin
          if (tick) begin
            rx_tcnt_q <= rx_tcnt_q + 4'd1;
            if (rx_tcnt_q == 4'd15) begin
              rx_perr_q  <= rx_in ^ (rx_odd_q ? ~^rx_sh_q : ^rx_sh_q);
              rx_state_q <= RxStop;
            end
          end
        end
        RxStop: begin
          if (tick) begin
            rx_tcnt_q <= rx_tcnt_q + 4'd1;
            if (rx_tcnt_q == 4'd15) begin
              rx_push_q      <= 1'b1;
              rx_push_data_q <= {~rx_in, rx_perr_q, rx_sh_q};
              rx_state_q     <= rx_in ? RxIdle : RxWait;
            end
          end
        end
        RxWait: begin
          if (rx_in) rx_state_q <= RxIdle;
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [EW-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]   rx_wptr_q, rx_rptr_q;
  logic          rx_empty, rx_full, rx_rd, rx_wr, overrun_q;
  logic [EW-1:0] rx_head;

  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                    (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
  assign rx_rd    = RD_EN && !rx_empty;
  assign rx_wr    = rx_push_q && (!rx_full || rx_rd);
  assign rx_head  = rx_mem[rx_rptr_q[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (rx_wr) rx_mem[rx_wptr_q[AW-1:0]] <= rx_push_data_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (rx_wr) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_rd) rx_rptr_q <= rx_rptr_q + 1'b1;
      if (rx_push_q && !rx_wr) begin
        overrun_q <= 1'b1;
      end else if (CFG_WE) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign RD_DATA    = rx_empty ? '0 : rx_head[DATA_W-1:0];
  assign RD_PERR    = rx_empty ? 1'b0 : rx_head[DATA_W];
  assign RD_FERR    = rx_empty ? 1'b0 : rx_head[DATA_W+1];
  assign RX_EMPTY   = rx_empty;
  assign RX_OVERRUN = overrun_q;
  assign IRQ        = !rx_empty || overrun_q;

endmodule

// File: tb/tb_uart_engine.sv
// Self-checking bench for uart_engine: RX vector table plus loopback, overrun, false-start
// and reset-abort sequences, with a scoreboard queue of expected RX entries.
module tb_uart_engine;

  logic       CLK = 1'b0;
  logic       RST;
  logic       WR_EN;
  logic [7:0] WR_DATA;
  logic       TX_FULL, TX_BUSY;
  logic       RD_EN;
  logic [7:0] RD_DATA;
  logic       RD_PERR, RD_FERR, RX_EMPTY, RX_OVERRUN;
  logic       CFG_WE;
  logic [15:0] CFG_DIV;
  logic [1:0] CFG_PARITY;
  logic       CFG_STOP2;
  logic       IRQ;
  logic       TX;
  logic       rx_drv;
  logic       loop;
  wire        rx_pin = loop ? TX : rx_drv;

  always #5 CLK = ~CLK;

  uart_engine #(.DATA_W(8), .FIFO_DEPTH(4), .DEFAULT_DIV(26)) dut (
    .CLK(CLK), .RST(RST),
    .WR_EN(WR_EN), .WR_DATA(WR_DATA), .TX_FULL(TX_FULL), .TX_BUSY(TX_BUSY),
    .RD_EN(RD_EN), .RD_DATA(RD_DATA), .RD_PERR(RD_PERR), .RD_FERR(RD_FERR),
    .RX_EMPTY(RX_EMPTY), .RX_OVERRUN(RX_OVERRUN),
    .CFG_WE(CFG_WE), .CFG_DIV(CFG_DIV), .CFG_PARITY(CFG_PARITY), .CFG_STOP2(CFG_STOP2),
    .IRQ(IRQ),
`ifdef UART_LOOPBACK_EN
    .LOOPBACK(1'b0),
`endif
    .RX(rx_pin), .TX(TX)
  );

  typedef struct {
    logic [7:0] d;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [1:0] par;
    logic [7:0] data;
    logic       bad_par;
    logic       bad_stop;
    logic       eperr;
    logic       eferr;
  } vec_t;

  exp_t sb[$];
  vec_t vecs [8];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   div_cur = 26;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_cfg(input int d, input logic [1:0] p, input logic s2);
    CFG_DIV = 16'(d); CFG_PARITY = p; CFG_STOP2 = s2; CFG_WE = 1'b1;
    @(negedge CLK);
    CFG_WE = 1'b0;
    div_cur = d;
  endtask

  task automatic write_word(input logic [7:0] d);
    WR_EN = 1'b1; WR_DATA = d;
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic [1:0] p, input logic bad_par,
                         input logic bad_stop);
    int bp = 16 * (div_cur + 1);
    rx_drv = 1'b0; clks(bp);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i]; clks(bp);
    end
    if (p == 2'b01 || p == 2'b10) begin
      rx_drv = ((p == 2'b10) ? ~^d : ^d) ^ bad_par; clks(bp);
    end
    rx_drv = ~bad_stop; clks(bp);
    rx_drv = 1'b1; clks(bp);
  endtask

  task automatic add_frame(input logic [7:0] d, input logic [1:0] p, input logic s2,
                           inout logic [31:0] b, inout int n);
    b[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin
      b[n] = d[i]; n++;
    end
    if (p == 2'b01) begin b[n] = ^d; n++; end
    if (p == 2'b10) begin b[n] = ~^d; n++; end
    b[n] = 1'b1; n++;
    if (s2) begin b[n] = 1'b1; n++; end
  endtask

  // Waits for the start bit, then samples TX at the middle of each bit.
  task automatic capture_tx(input string name, input int nbits, output logic [31:0] bits);
    int bp = 16 * (div_cur + 1);
    int t = 0;
    bits = '0;
    while (TX !== 1'b0 && t < 4 * bp) begin
      @(negedge CLK); t++;
    end
    chk({name, ".start_seen"}, 32'(TX), 32'd0);
    if (TX === 1'b0) begin
      clks(bp / 2);
      bits[0] = TX;
      for (int k = 1; k < nbits; k++) begin
        clks(bp);
        bits[k] = TX;
      end
    end
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    int   lim = 24 * 16 * (div_cur + 1) + 200;
    int   t = 0;
    while (RX_EMPTY && t < lim) begin
      @(negedge CLK); t++;
    end
    chk({name, ".avail"}, 32'(RX_EMPTY), 32'd0);
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s.sb: got entry, expected none queued", name);
    end else if (!RX_EMPTY) begin
      e = sb.pop_front();
      chk({name, ".data"}, 32'(RD_DATA), 32'(e.d));
      chk({name, ".perr"}, 32'(RD_PERR), 32'(e.perr));
      chk({name, ".ferr"}, 32'(RD_FERR), 32'(e.ferr));
      chk({name, ".irq"},  32'(IRQ),     32'd1);
      RD_EN = 1'b1;
      @(negedge CLK);
      RD_EN = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] got, expb;
    int n, zeros;
    exp_t e;

    vecs[0] = '{2'b00, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{2'b00, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'b10, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{2'b01, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{2'b01, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{2'b10, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2'b01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};

    RST = 1'b1; WR_EN = 1'b0; WR_DATA = '0; RD_EN = 1'b0; CFG_WE = 1'b0;
    CFG_DIV = 16'd26; CFG_PARITY = 2'b00; CFG_STOP2 = 1'b0; rx_drv = 1'b1; loop = 1'b0;
    clks(3);
    chk("rst.tx",      32'(TX),         32'd1);
    chk("rst.busy",    32'(TX_BUSY),    32'd0);
    chk("rst.full",    32'(TX_FULL),    32'd0);
    chk("rst.empty",   32'(RX_EMPTY),   32'd1);
    chk("rst.rd_data", 32'(RD_DATA),    32'd0);
    chk("rst.perr",    32'(RD_PERR),    32'd0);
    chk("rst.ferr",    32'(RD_FERR),    32'd0);
    chk("rst.overrun", 32'(RX_OVERRUN), 32'd0);
    chk("rst.irq",     32'(IRQ),        32'd0);
    RST = 1'b0;
    clks(2);

    // Loopback A5, DIV=26, even parity.
    loop = 1'b1;
    set_cfg(26, 2'b01, 1'b0);
    write_word(8'hA5);
    chk("lb.busy", 32'(TX_BUSY), 32'd1);
    sb.push_back('{8'hA5, 1'b0, 1'b0});
    expb = '0; n = 0;
    add_frame(8'hA5, 2'b01, 1'b0, expb, n);
    capture_tx("lb", n, got);
    chk("lb.tx_bits", got, expb);
    pop_check("lb");
    clks(16 * 27);
    chk("lb.idle_busy", 32'(TX_BUSY), 32'd0);

    // Two stop bits, back-to-back frames, no parity.
    set_cfg(3, 2'b00, 1'b1);
    write_word(8'h3C);
    write_word(8'hC3);
    sb.push_back('{8'h3C, 1'b0, 1'b0});
    sb.push_back('{8'hC3, 1'b0, 1'b0});
    expb = '0; n = 0;
    add_frame(8'h3C, 2'b00, 1'b1, expb, n);
    add_frame(8'hC3, 2'b00, 1'b1, expb, n);
    capture_tx("stop2", n, got);
    chk("stop2.tx_bits", got, expb);
    pop_check("stop2.a");
    pop_check("stop2.b");

    // Odd parity TX.
    set_cfg(3, 2'b10, 1'b0);
    write_word(8'h3C);
    sb.push_back('{8'h3C, 1'b0, 1'b0});
    expb = '0; n = 0;
    add_frame(8'h3C, 2'b10, 1'b0, expb, n);
    capture_tx("odd", n, got);
    chk("odd.tx_bits", got, expb);
    pop_check("odd");

    // TX FIFO fills while the divider is slow; fifth write is dropped.
    set_cfg(1000, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      write_word(8'(8'h40 + i));
      if (i < 4) sb.push_back('{8'(8'h40 + i), 1'b0, 1'b0});
    end
    chk("txfull.full", 32'(TX_FULL), 32'd1);
    set_cfg(3, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) pop_check($sformatf("txfull%0d", i));
    clks(2 * 16 * 11 * 4);
    chk("txfull.no5th", 32'(RX_EMPTY), 32'd1);
    chk("txfull.ovr",   32'(RX_OVERRUN), 32'd0);
    loop = 1'b0;

    // RX vector table.
    for (int i = 0; i < 8; i++) begin
      set_cfg(3, vecs[i].par, 1'b0);
      sb.push_back('{vecs[i].data, vecs[i].eperr, vecs[i].eferr});
      send_rx(vecs[i].data, vecs[i].par, vecs[i].bad_par, vecs[i].bad_stop);
      pop_check($sformatf("vec%0d", i));
    end

    // False start, then a valid frame still gets through.
    set_cfg(3, 2'b00, 1'b0);
    rx_drv = 1'b0; clks(4 * 4);
    rx_drv = 1'b1; clks(2 * 64);
    chk("fstart.empty", 32'(RX_EMPTY), 32'd1);
    sb.push_back('{8'h55, 1'b0, 1'b0});
    send_rx(8'h55, 2'b00, 1'b0, 1'b0);
    pop_check("fstart.after");

    // Read on empty is ignored.
    RD_EN = 1'b1; @(negedge CLK); RD_EN = 1'b0;
    chk("rdempty.empty", 32'(RX_EMPTY), 32'd1);
    chk("rdempty.data",  32'(RD_DATA),  32'd0);

    // RX overrun with depth 4.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb.push_back('{8'(8'h90 + i), 1'b0, 1'b0});
      send_rx(8'(8'h90 + i), 2'b00, 1'b0, 1'b0);
    end
    chk("ovr.set",   32'(RX_OVERRUN), 32'd1);
    chk("ovr.irq",   32'(IRQ),        32'd1);
    set_cfg(3, 2'b00, 1'b0);
    chk("ovr.clear", 32'(RX_OVERRUN), 32'd0);
    for (int i = 0; i < 4; i++) pop_check($sformatf("ovr%0d", i));
    chk("ovr.irq_end",   32'(IRQ),      32'd0);
    chk("ovr.empty_end", 32'(RX_EMPTY), 32'd1);

    // Reset mid-TX with three words still queued.
    write_word(8'hF0); write_word(8'h0F); write_word(8'hAA); write_word(8'h55);
    n = 0;
    while (TX !== 1'b0 && n < 400) begin
      @(negedge CLK); n++;
    end
    chk("rstmid.started", 32'(TX), 32'd0);
    clks(3 * 64);
    RST = 1'b1;
    #1;
    chk("rstmid.tx",   32'(TX),      32'd1);
    chk("rstmid.busy", 32'(TX_BUSY), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    div_cur = 26;
    zeros = 0;
    for (int i = 0; i < 2 * 11 * 16 * 27; i++) begin
      @(negedge CLK);
      if (TX !== 1'b1) zeros++;
    end
    chk("rstmid.silent",     32'(zeros),   32'd0);
    chk("rstmid.busy_after", 32'(TX_BUSY), 32'd0);

    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL sb.leftover: got %0d entries, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
